// File: rtl/matrix_mult_pkg.sv
// Shared types for the systolic matrix multiplier front ends.
// Holds the external-mode FSM encoding and the result-FIFO entry layout.
package matrix_mult_pkg;

    localparam int unsigned MM_WIDTH = 8;
    localparam int unsigned MM_ROW   = 4;
    localparam int unsigned MM_COL   = 4;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_LOAD_W,
        MM_STREAM,
        MM_DRAIN
    } mm_ext_state_e;

    typedef struct packed {
        logic                               last;
        logic [MM_COL-1:0][MM_WIDTH-1:0]    data;
    } mm_result_t;

    localparam int unsigned MM_RESULT_W = $bits(mm_result_t);

endpackage

// File: rtl/mm_result_fifo.sv
// Synchronous result FIFO with occupancy count; registered output, no fall-through.
// Head data reads as zero while empty so downstream never sees stale entries.
module mm_result_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ENTRY_W = 33
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [ENTRY_W-1:0]           data_i,
    input  logic                         pop_i,
    output logic [ENTRY_W-1:0]           data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]   wr_ptr_q;
    logic [AddrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]    count_q;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CntW'(DEPTH));
        do_pop  = pop_i & ~empty;
        // A pop in the same cycle frees the slot the push lands in.
        do_push = push_i & (~full | do_pop);
        valid_o = ~empty;
        count_o = count_q;
        data_o  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/matrix_mult_ext_stream.sv
// External-mode stream front end for the systolic array: weight load, vector issue,
// latency-matched result capture and credit-based backpressure into a result FIFO.
module matrix_mult_ext_stream
    import matrix_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = MM_WIDTH,
    parameter int unsigned ROW         = MM_ROW,
    parameter int unsigned COL         = MM_COL,
    parameter int unsigned ARRAY_LAT   = ROW + COL,
    parameter int unsigned OFIFO_DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [COL*WIDTH-1:0]   w_data_i,
    input  logic                   x_valid_i,
    output logic                   x_ready_o,
    input  logic [ROW*WIDTH-1:0]   x_data_i,
    input  logic                   x_last_i,
    output logic [COL*WIDTH-1:0]   sa_north_o,
    output logic [ROW*WIDTH-1:0]   sa_west_o,
    output logic [ROW*COL-1:0]     sa_load_o,
    output logic [ROW*COL-1:0]     sa_sum_out_o,
    input  logic [COL*WIDTH-1:0]   sa_south_i,
    output logic                   y_valid_o,
    input  logic                   y_ready_i,
    output logic [COL*WIDTH-1:0]   y_data_o,
    output logic                   y_last_o,
    output logic                   busy_o
);

    localparam int unsigned EntryW  = COL * WIDTH + 1;
    localparam int unsigned CntW    = $clog2(OFIFO_DEPTH + 1);
    localparam int unsigned CreditW = $clog2(OFIFO_DEPTH + 1) + 1;
    localparam int unsigned WCntW   = (ROW > 1) ? $clog2(ROW) : 1;

    mm_ext_state_e state_q, state_d;
    logic [WCntW-1:0]     w_cnt_q, w_cnt_d;
    logic [ARRAY_LAT-1:0] infl_valid_q;
    logic [ARRAY_LAT-1:0] infl_last_q;

    logic               w_fire;
    logic               x_fire;
    logic               y_fire;
    logic [CreditW-1:0] infl_cnt;
    logic [CreditW-1:0] credit;

    logic               fifo_push;
    logic [EntryW-1:0]  fifo_wdata;
    logic [EntryW-1:0]  fifo_rdata;
    logic               fifo_valid;
    logic [CntW-1:0]    fifo_count;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < ARRAY_LAT; i++) begin
            infl_cnt = infl_cnt + CreditW'(infl_valid_q[i]);
        end
    end

    always_comb begin
        y_valid_o = en_i & fifo_valid;
        y_fire    = y_valid_o & y_ready_i;
        // Every issued vector owns a FIFO slot from issue until it is popped.
        credit    = CreditW'(OFIFO_DEPTH) - CreditW'(fifo_count) - infl_cnt
                    + CreditW'(y_fire);

        w_ready_o = en_i && (state_q == MM_LOAD_W);
        x_ready_o = en_i && (state_q == MM_STREAM) && !credit[CreditW-1] && (credit != '0);
        w_fire    = w_valid_i & w_ready_o;
        x_fire    = x_valid_i & x_ready_o;

        sa_north_o   = w_fire ? w_data_i : '0;
        sa_load_o    = {(ROW*COL){w_fire}};
        sa_west_o    = x_fire ? x_data_i : '0;
        sa_sum_out_o = {(ROW*COL){x_fire}};

        fifo_push  = infl_valid_q[ARRAY_LAT-1];
        fifo_wdata = {infl_last_q[ARRAY_LAT-1], sa_south_i};

        y_data_o = en_i ? fifo_rdata[COL*WIDTH-1:0] : '0;
        y_last_o = en_i & fifo_rdata[EntryW-1];
        busy_o   = en_i && ((state_q != MM_IDLE) || fifo_valid);
    end

    always_comb begin
        state_d = state_q;
        w_cnt_d = w_cnt_q;
        case (state_q)
            MM_IDLE: begin
                w_cnt_d = '0;
                if (w_valid_i) begin
                    state_d = MM_LOAD_W;
                end
            end
            MM_LOAD_W: begin
                if (w_fire) begin
                    if (w_cnt_q == WCntW'(ROW - 1)) begin
                        state_d = MM_STREAM;
                        w_cnt_d = '0;
                    end else begin
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
            end
            MM_STREAM: begin
                if (x_fire && x_last_i) begin
                    state_d = MM_DRAIN;
                end
            end
            MM_DRAIN: begin
                if (infl_valid_q == '0) begin
                    state_d = MM_IDLE;
                end
            end
            default: state_d = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q      <= MM_IDLE;
            w_cnt_q      <= '0;
            infl_valid_q <= '0;
            infl_last_q  <= '0;
        end else begin
            state_q      <= state_d;
            w_cnt_q      <= w_cnt_d;
            infl_valid_q <= {infl_valid_q[ARRAY_LAT-2:0], x_fire};
            infl_last_q  <= {infl_last_q[ARRAY_LAT-2:0], x_fire & x_last_i};
        end
    end

    mm_result_fifo #(
        .DEPTH   (OFIFO_DEPTH),
        .ENTRY_W (EntryW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~en_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (y_fire),
        .data_o  (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

endmodule
